ahb_lite_interconnect: RTL
==========================

AHB_LITE_INTERCONNECT -- requirements
Module: ahb_lite_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (legal 1..16).
REQ-002 SHALL have parameter SLV_BASE, default {16'h4001,16'h4000,16'h2000,16'h0000}, packed NUM_SLAVES x 16-bit region bases, slave 0 in bits [15:0].
REQ-003 SHALL have parameter SLV_MASK, default {4{16'hFFFF}}, packed NUM_SLAVES x 16-bit masks applied to HADDR[31:16].
REQ-004 SHALL have port HCLK  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port HRESETn  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports HADDR/HTRANS/HWRITE/HSIZE  input  32/2/1/3  master address-phase signals.
REQ-007 SHALL have port HRDATA  output  32  read data to master.
REQ-008 SHALL have port HREADY  output  1  transfer done to master.
REQ-009 SHALL have port HRESP  output  1  response to master.
REQ-010 SHALL have port HSEL_S  output  NUM_SLAVES  one-hot slave select.
REQ-011 SHALL have port HREADYMUX_S  output  1  muxed ready broadcast to all slaves.
REQ-012 SHALL have port HRDATA_S  input  NUM_SLAVES*32  slave read data, slave i in [32i+31:32i].
REQ-013 SHALL have ports HREADYOUT_S/HRESP_S  input  NUM_SLAVES each  per-slave ready/response.
REQ-014 SHALL have ports ERR_CLR input 1, ERR_VALID output 1, ERR_ADDR output 32  decode-error capture (see Configuration).

Function
REQ-015 SHALL assert HSEL_S[i] combinationally when (HADDR[31:16] & SLV_MASK_i) == SLV_BASE_i; on overlap, only the lowest i SHALL be asserted.
REQ-016 SHALL select the internal default slave when no region matches.
REQ-017 SHALL register the data-phase selection (slave index or default) on each HCLK edge where HREADY=1, independent of HTRANS.
REQ-018 SHALL drive HRDATA, HREADY, HRESP from the data-phase-selected slave with zero added latency; default slave HRDATA = 0.
REQ-019 SHALL drive HREADYMUX_S equal to HREADY.
REQ-020 Default slave FSM states: DS_OK, DS_ERR1, DS_ERR2.
REQ-021 DS_OK: HREADY=1, HRESP=0; an unmapped NONSEQ/SEQ accepted (HREADY=1) SHALL transition to DS_ERR1; an IDLE/BUSY SHALL remain in DS_OK.
REQ-022 DS_ERR1: HREADY=0, HRESP=1, unconditionally to DS_ERR2 next cycle.
REQ-023 DS_ERR2: HREADY=1, HRESP=1; next state DS_ERR1 if another unmapped NONSEQ/SEQ is presented, else DS_OK.
REQ-024 Back-to-back transfers to different slaves SHALL switch the data-phase mux without bubble cycles.
REQ-025 While HREADY=0, address-phase changes SHALL NOT update the data-phase selection.

Reset
REQ-026 On HRESETn low, asynchronously: data-phase selection = default slave, FSM = DS_OK, HREADY=1, HRESP=0, HRDATA=0, ERR_VALID=0, ERR_ADDR=0.
REQ-027 Reset asserted mid-transfer (including DS_ERR1) SHALL abort immediately to reset values; first transfer after release SHALL decode normally.

Configuration
REQ-028 Macro AHB_IC_ERR_CAPTURE_EN defined: on entry to DS_ERR1, ERR_ADDR SHALL capture the erroring HADDR and ERR_VALID SHALL set (sticky); ERR_CLR=1 SHALL clear ERR_VALID next edge; simultaneous new error and ERR_CLR: error wins.
REQ-029 Macro AHB_IC_ERR_CAPTURE_EN undefined: ERR_VALID and ERR_ADDR SHALL be tied 0, ERR_CLR ignored, no capture flops present.

Verification
REQ-030 NONSEQ read 0x2000_0010, slave 1 HRDATA_S=0xCAFE_F00D, ready -> HSEL_S=4'b0010, next cycle HRDATA=0xCAFE_F00D, HREADY=1, HRESP=0.
REQ-031 NONSEQ to 0x9000_0000 -> HREADY 0 then 1 with HRESP=1 both cycles; with macro ERR_ADDR=0x9000_0000, ERR_VALID=1 until ERR_CLR pulse.
REQ-032 Slave 2 inserts 3 wait states while next address targets slave 0 -> HSEL_S[0] asserted, data mux stays on slave 2 until HREADYOUT_S[2]=1, then switches with no bubble.
REQ-033 Two consecutive unmapped NONSEQs -> sequence ERR1,ERR2,ERR1,ERR2; HREADY 0,1,0,1; HRESP 1 throughout.
REQ-034 HRESETn pulsed low during DS_ERR1 -> same cycle HREADY=1, HRESP=0, ERR_VALID=0; following read to 0x0000_0004 completes OKAY from slave 0.
REQ-035 NUM_SLAVES=2, overlapping regions base 0x4000 mask 0xF000 for both -> access 0x4000_0000 selects slave 0 only.

Source files
------------

// File: rtl/ahb_lite_interconnect.sv
// rtl/ahb_lite_interconnect.sv - AHB-Lite address decoder, response mux and default slave
// Optional decode-error capture (ERR_VALID/ERR_ADDR): define AHB_IC_ERR_CAPTURE_EN.
module ahb_lite_interconnect #(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*16-1:0]  SLV_BASE   = {16'h4001, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [NUM_SLAVES*16-1:0]  SLV_MASK   = {4{16'hFFFF}}
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  output logic [31:0]              HRDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [NUM_SLAVES-1:0]    HSEL_S,
  output logic                     HREADYMUX_S,
  input  logic [NUM_SLAVES*32-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]    HRESP_S,
  input  logic                     ERR_CLR,
  output logic                     ERR_VALID,
  output logic [31:0]              ERR_ADDR
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_t;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic [IW-1:0]         dec_idx;
  logic                  dec_hit;

  logic [IW-1:0]         dp_idx;
  logic                  dp_def;

  ds_state_t             ds_state;
  logic                  ds_ready;
  logic                  ds_resp;
  logic                  ds_req;

  logic [31:0]           mux_rdata;
  logic                  mux_ready;
  logic                  mux_resp;

  // Descending scan so the lowest matching region is the one left standing.
  always_comb begin
    dec_sel = '0;
    dec_idx = '0;
    dec_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR[31:16] & SLV_MASK[i*16 +: 16]) == SLV_BASE[i*16 +: 16]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
        dec_idx    = IW'(i);
        dec_hit    = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_def <= 1'b1;
      dp_idx <= '0;
    end else if (mux_ready) begin
      dp_def <= ~dec_hit;
      dp_idx <= dec_idx;
    end
  end

  always_comb begin
    mux_rdata = '0;
    mux_ready = ds_ready;
    mux_resp  = ds_resp;
    if (!dp_def) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (dp_idx == IW'(i)) begin
          mux_rdata = HRDATA_S[i*32 +: 32];
          mux_ready = HREADYOUT_S[i];
          mux_resp  = HRESP_S[i];
        end
      end
    end
  end

  // An unmapped active transfer being accepted on the bus this cycle.
  assign ds_req = ~dec_hit & HTRANS[1] & mux_ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ds_state <= DS_OK;
      ds_ready <= 1'b1;
      ds_resp  <= 1'b0;
    end else begin
      case (ds_state)
        DS_OK: begin
          if (ds_req) begin
            ds_state <= DS_ERR1;
            ds_ready <= 1'b0;
            ds_resp  <= 1'b1;
          end
        end
        DS_ERR1: begin
          ds_state <= DS_ERR2;
          ds_ready <= 1'b1;
          ds_resp  <= 1'b1;
        end
        DS_ERR2: begin
          if (ds_req) begin
            ds_state <= DS_ERR1;
            ds_ready <= 1'b0;
            ds_resp  <= 1'b1;
          end else begin
            ds_state <= DS_OK;
            ds_ready <= 1'b1;
            ds_resp  <= 1'b0;
          end
        end
        default: begin
          ds_state <= DS_OK;
          ds_ready <= 1'b1;
          ds_resp  <= 1'b0;
        end
      endcase
    end
  end

  assign HSEL_S      = dec_sel;
  assign HRDATA      = mux_rdata;
  assign HREADY      = mux_ready;
  assign HRESP       = mux_resp;
  assign HREADYMUX_S = mux_ready;

`ifdef AHB_IC_ERR_CAPTURE_EN
  logic        err_valid_q;
  logic [31:0] err_addr_q;

  // A fresh error outranks a clear landing on the same edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (ds_req) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= HADDR;
    end else if (ERR_CLR) begin
      err_valid_q <= 1'b0;
    end
  end

  assign ERR_VALID = err_valid_q;
  assign ERR_ADDR  = err_addr_q;
`else
  logic unused_clr;
  assign unused_clr = ERR_CLR;
  assign ERR_VALID  = 1'b0;
  assign ERR_ADDR   = '0;
`endif

  logic unused_bus;
  assign unused_bus = ^{HWRITE, HSIZE, HTRANS[0], HADDR[15:0]};

endmodule
